// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the sequence-detector path. Words arrive
//   over a valid/ready handshake and leave one bit per clock, MSB first. A
//   single-word hold register lets the next word be taken while the current
//   one is still shifting, so back-to-back frames stream with no idle gap.
//
// Parameters
//   WIDTH     data bits per word (2..32)
//   IDLE_BIT  level driven on ser_out while nothing is shifting
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_data     word to serialize
//   in_valid    in_data valid this cycle
//   in_ready    block can take a word this cycle (hold register empty)
//   ser_out     serial bit to the detector
//   ser_valid   ser_out carries a frame bit
//   frame_done  pulse on the last bit of each frame
//   busy        a frame is shifting or the hold register is occupied
//
// Build option
//   SER_PARITY_EN  appends an even-parity bit after the data bits of
//                  every frame (frame length WIDTH+1)
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int   WIDTH    = 6,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } st_t;

  st_t              st, st_nxt;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  logic xfer;
  logic data_last;
  logic last_bit;
  logic load_hold;
  logic load_direct;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign in_ready  = !hold_full;
  assign xfer      = in_valid && in_ready;
  assign data_last = (st == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

`ifdef SER_PARITY_EN
  assign last_bit  = (st == ST_PAR);
`else
  assign last_bit  = data_last;
`endif

  // The hold word always has priority at end of frame; a new word only goes
  // straight into the shifter when nothing is waiting ahead of it.
  assign load_hold   = last_bit && hold_full;
  assign load_direct = xfer && !hold_full && ((st == ST_IDLE) || last_bit);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: begin
        if (load_direct) st_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (data_last) begin
`ifdef SER_PARITY_EN
          st_nxt = ST_PAR;
`else
          st_nxt = (load_hold || load_direct) ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
      ST_PAR: begin
        st_nxt = (load_hold || load_direct) ? ST_SHIFT : ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    ser_out    = IDLE_BIT;
    ser_valid  = 1'b0;
    frame_done = 1'b0;
    case (st)
      ST_SHIFT: begin
        ser_out    = sh[WIDTH-1];
        ser_valid  = 1'b1;
        frame_done = last_bit;
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        ser_out    = par;
        ser_valid  = 1'b1;
        frame_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (st != ST_IDLE) || hold_full;

  // Shifter, bit counter and parity capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
`ifdef SER_PARITY_EN
      par <= 1'b0;
`endif
    end else if (load_hold) begin
      sh  <= hold;
      cnt <= '0;
`ifdef SER_PARITY_EN
      par <= even_parity(hold);
`endif
    end else if (load_direct) begin
      sh  <= in_data;
      cnt <= '0;
`ifdef SER_PARITY_EN
      par <= even_parity(in_data);
`endif
    end else if (st == ST_SHIFT) begin
      sh  <= sh << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Hold register: filled by any transfer that cannot go straight into the
  // shifter, drained at end of frame. A refill in the drain edge keeps the
  // flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (xfer && !load_direct) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end else if (load_hold) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  localparam int W = 6;
`ifdef SER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  logic rdy0, so0, sv0, fd0, bz0;
  logic rdy1, so1, sv1, fd1, bz1;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .ser_out(so0), .ser_valid(sv0), .frame_done(fd0), .busy(bz0)
  );

  bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .ser_out(so1), .ser_valid(sv1), .frame_done(fd1), .busy(bz1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: the serial stream is a FIFO of pending bits {last, bit}; one
  // bit leaves per clock, an accepted word appends its whole frame. A word
  // can be accepted while at most one frame's worth of bits is pending.
  logic [1:0]  q[$];
  logic [31:0] obs = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--)
      q.push_back({(i == 0) && (F == W), d[i]});
`ifdef SER_PARITY_EN
    q.push_back({1'b1, ^d});
`endif
  endtask

  task automatic check_outputs();
    logic       ev;
    logic [1:0] h;
    ev = (q.size() > 0);
    h  = ev ? q[0] : 2'b00;
    check("ser_valid",   sv0, ev);
    check("ser_valid_1", sv1, ev);
    check("ser_out",     so0, ev ? h[0] : 1'b0);
    check("ser_out_1",   so1, ev ? h[0] : 1'b1);
    check("frame_done",  fd0, h[1]);
    check("frame_done_1", fd1, h[1]);
    check("busy",        bz0, ev);
    check("busy_1",      bz1, ev);
    check("in_ready",    rdy0, int'(q.size()) <= F);
    check("in_ready_1",  rdy1, int'(q.size()) <= F);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    logic acc;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    acc = v && (int'(q.size()) <= F) && reset;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_word(d);
    @(negedge clk);
    obs = {obs[30:0], so0};
    check_outputs();
  endtask

  task automatic check_reset_state();
    check("rst_ser_valid",  sv0, 1'b0);
    check("rst_busy",       bz0, 1'b0);
    check("rst_frame_done", fd0, 1'b0);
    check("rst_in_ready",   rdy0, 1'b1);
    check("rst_ser_out",    so0, 1'b0);
    check("rst_ser_out_1",  so1, 1'b1);
  endtask

  initial begin
    // Reset asserted from time zero
    #1;
    check_reset_state();
    step(1'b1, 6'b110011);
    step(1'b1, 6'b110011);
    reset = 1'b1;
    check_outputs();

    // Single frame into an idle block
    step(1'b1, 6'b101011);
    for (int i = 0; i < W - 1; i++) step(1'b0, 6'b000000);
    check("frame_bits", obs[W-1:0], 6'b101011);
    for (int i = 0; i < 4; i++) step(1'b0, 6'($urandom));

    // Back-to-back with hold register
    step(1'b1, 6'b101011);
    step(1'b1, 6'b111111);
    for (int i = 0; i < 2 * F + 2; i++) step(1'b0, 6'($urandom));

    // Long idle
    for (int i = 0; i < 20; i++) step(1'b0, 6'($urandom));

    // Reset mid-frame with a word held
    step(1'b1, 6'b100110);
    step(1'b1, 6'b011001);
    step(1'b0, 6'b000000);
    step(1'b0, 6'b000000);
    #2 reset = 1'b0;
    #1;
    q.delete();
    check_reset_state();
    step(1'b1, 6'b111000);
    step(1'b1, 6'b111000);
    reset = 1'b1;
    check_outputs();
    step(1'b1, 6'b110001);
    for (int i = 0; i < W - 1; i++) step(1'b0, 6'b000000);
    check("fresh_frame", obs[W-1:0], 6'b110001);
    for (int i = 0; i < F + 2; i++) step(1'b0, 6'($urandom));

    // Randomized traffic, mixing sparse and saturated valid
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int i = 0; i < 80; i++)
        step(($urandom_range(0, 3) < dens), 6'($urandom));
    end

    for (int i = 0; i < 3 * F; i++) step(1'b0, 6'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single-bit stream that drives the detector's `in` port. A one-word holding register lets a following word be accepted while the current word is still shifting, so consecutive frames stream with no idle gap.

## Interface
- `WIDTH`, 6: data bits per word, 2..32.
- `IDLE_BIT`, 1'b0: value driven on `ser_out` when no frame is shifting.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset: low clears all state immediately; deassertion is sampled on `clk`.
- `in_data`  input  WIDTH  word to serialize.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  block can accept a word this cycle.
- `ser_out`  output  1  serial bit, feeds the detector `in`.
- `ser_valid`  output  1  high while `ser_out` carries a frame bit.
- `frame_done`  output  1  one-cycle pulse coincident with the last bit of each frame.
- `busy`  output  1  a frame is shifting or the hold register is occupied.

## Operation
- Storage: shift register `sh[WIDTH-1:0]`, bit counter `cnt` (width clog2(FRAME_LEN)), hold register `hold` with flag `hold_full`, state `st`.
- FRAME_LEN = WIDTH, or WIDTH+1 with parity (see Configuration).
- States: IDLE (nothing shifting), SHIFT (data bits), PAR (parity bit, only with the macro).
- Handshake: a transfer occurs on an edge where `in_valid && in_ready && reset`. `in_ready = !hold_full`, combinational.
- Accepted word routing at the transfer edge:
  - if st==IDLE, or the current cycle is the frame's last bit, and `hold_full`==0: load `sh` directly, `cnt`=0, st=SHIFT.
  - otherwise: write `hold`, set `hold_full`.
- End of frame, on the edge ending the last bit: if `hold_full`, load `sh` from `hold`, clear `hold_full`, st=SHIFT, `cnt`=0. Otherwise, if a direct load (above) happens, take that. Otherwise st=IDLE.
- Transfer and hold-drain in the same edge: the hold word loads into `sh` and the new word goes into `hold`, so `hold_full` stays 1.
- SHIFT: `ser_out = sh[WIDTH-1]`, `sh` shifts left each cycle, `cnt` increments; the last data bit is at cnt==WIDTH-1.
- `ser_out` = IDLE_BIT and `ser_valid` = 0 whenever st==IDLE.
- `busy = (st!=IDLE) || hold_full`.
- Words are never dropped or reordered. `in_data` is ignored when no transfer occurs.

## Timing
- Reset values, asserted and immediately after release: st=IDLE, `hold_full`=0, `ser_out`=IDLE_BIT, `ser_valid`=0, `frame_done`=0, `busy`=0, `in_ready`=1. No transfer is taken while `reset` is low.
- Latency: a word accepted at edge k into an idle block puts its MSB on `ser_out` in the cycle after edge k. Bit i (MSB=0) appears in cycle k+1+i.
- Outputs `ser_out`, `ser_valid`, `frame_done` are registered or decoded from registered state only. No combinational path from `in_*` to them.
- Back-to-back: with the hold register or a direct load ready at end of frame, the next frame's MSB follows the previous last bit in the very next cycle, and `ser_valid` stays high.
- `frame_done` is high in the same cycle as the last bit of the frame (last data bit, or the parity bit).
- Reset asserted mid-frame: the frame is abandoned and the hold word is discarded. Outputs return to reset values asynchronously. There is no partial-frame resume.

## Configuration
- `SER_PARITY_EN` defined: FRAME_LEN = WIDTH+1.
  - After the last data bit, st=PAR for one cycle and `ser_out` = even parity (XOR of the frame's WIDTH data bits, captured at load).
  - `ser_valid`=1 and `frame_done`=1 in that cycle.
  - End-of-frame loading happens on the edge ending the PAR cycle.
- Not defined: PAR state, parity logic and parity register are absent, and FRAME_LEN = WIDTH.

## Test plan
- WIDTH=6, macro off. Reset low for 2 cycles, then send 6'b101011 once → `ser_out` = 1,0,1,0,1,1 in cycles k+1..k+6. `ser_valid` is high for exactly those 6 cycles, `frame_done` only in cycle k+6, then `ser_out`=0 (IDLE_BIT). The detector downstream flags the pattern.
- Hold `in_valid`=1 with 6'b101011 then 6'b111111 → 12 contiguous valid bits with no gap. `in_ready` drops while the hold register is full. Exactly two transfers occur.
- Idle with no valid for 20 cycles → `ser_out`=IDLE_BIT, `ser_valid`=0, `busy`=0 throughout. Repeat with IDLE_BIT=1 → `ser_out`=1.
- Pull `reset` low in cycle k+3 of a frame with a word held → `ser_valid`, `busy`, `frame_done` are 0 immediately. After release, the next word sent starts a fresh frame at its MSB, and the discarded held word never appears.
- Macro on: send 6'b101011 → 7 valid bits, last bit 0. Send 6'b101010 → last bit 1. `frame_done` is on the 7th bit.
- Macro on: back-to-back 6'b000001, 6'b000011 → 14 contiguous bits 0000011 0000110.
